prach_c_sched: RTL
==================

# prach_c_sched

PRACH C-Plane request scheduler, sitting directly downstream of the C-Plane decoder (`prach_c_plane`).

- It captures each decoded PRACH section request (per-CC/antenna strobe, frequency offset, time offset, symbol count, U-Plane header) into a small FIFO.
- It releases each request at the frame-relative sample time it names, as a one-cycle start pulse with the matching parameters.
- It reports overflow and stale-request drops.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Power of two, ≥ 2.

Ports:
- `clk` in 1: `clk_eth_xran` domain clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `c_valid` in [3][8]: per-CC/antenna request strobe from the decoder. One cycle per request.
- `c_frequency_offset` in 17: signed PRACH frequency offset, captured with the request.
- `c_time_offset` in 20: release time in Ts within a 10 ms frame, range 0..614399.
- `c_num_symbol` in 4: PRACH symbol count.
- `c_header` in 120: U-Plane header for the request.
- `time_valid` in 1: one-cycle strobe; `time_cnt` takes a new value in this cycle.
- `time_cnt` in 20: current frame position in Ts, range 0..614399. Held stable between strobes.
- `prach_start` out [3][8]: one-cycle start pulse to the selected CC/antenna.
- `prach_freq_offset` out 17, `prach_num_symbol` out 4, `prach_header` out 120, `prach_time` out 20: parameters of the issued request. Valid while `prach_start` is high; held otherwise.
- `fifo_count` out $clog2(DEPTH)+1: current occupancy.
- `overflow_cnt` out 16: saturating count of requests lost because the FIFO was full.
- `drop_cnt` out 16: saturating count of stale requests discarded.
- `multi_hit_err` out 1: sticky flag, set when more than one `c_valid` bit is high in the same cycle.

## Operation
- Entry format: {cc 2b, ant 3b, freq 17b, time 20b, nsym 4b, header 120b}.
- Push: any `c_valid` bit high.
  - cc/ant is the set bit with the lowest index cc*8+ant.
  - If more than one bit is set, the lowest-index bit is still written and `multi_hit_err` is set.
- Full push: the entry is discarded, `overflow_cnt` increments (saturates at 16'hFFFF), and FIFO contents are unchanged.
- FIFO is strict in-order. Push and pop in the same cycle are legal; count is unchanged.
- State machine: IDLE, WAIT, ISSUE.
  - IDLE: FIFO empty. Goes to WAIT when `fifo_count` != 0.
  - WAIT: each cycle, compares the head time with `time_cnt` (level compare, independent of `time_valid`).
    - On a match, moves to ISSUE. At that edge it pops the head and registers all `prach_*` outputs.
    - `frame_ticks` counts cycles with `time_valid`=1 and `time_cnt`=0 while WAITing on the same head.
    - When a second tick arrives with no match: pop the head without a pulse, increment `drop_cnt`, reset `frame_ticks`, go to WAIT if more entries remain, else IDLE.
    - A match takes priority over a tick in the same cycle.
  - ISSUE: `prach_start[cc][ant]`=1 for exactly this cycle. Next state is WAIT if `fifo_count` != 0, else IDLE. `frame_ticks` clears.
- Several entries sharing a time (different antennas) issue back-to-back, one every 2 clk cycles, while `time_cnt` is held.
  - Requirement: clk / sample-strobe ratio ≥ 2*DEPTH.
- `prach_start` never has more than one bit high.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, FIFO empty, and all of the following are 0:
  - `prach_start`, `prach_freq_offset`, `prach_num_symbol`, `prach_header`, `prach_time`
  - `fifo_count`, `overflow_cnt`, `drop_cnt`, `multi_hit_err`, `frame_ticks`
- Reset mid-operation discards all queued entries. No pulse is emitted during or after reset until a new push.
- Push at cycle N: `fifo_count` updates at N+1, and the head is comparable from N+1.
  - Earliest `prach_start` is N+2 if `time_cnt` already equals the entry time.
- Match at cycle M: `prach_start` and `prach_*` are valid at M+1. `fifo_count` decrements at M+1.
- Drop at cycle M: `drop_cnt` and `fifo_count` update at M+1. `prach_*` outputs are unchanged.
- Counters saturate and never wrap.

## Test plan
- Single request: `c_valid[1][2]` with time=1000, freq=-5, nsym=12. Ramp `time_cnt`.
  - Expect `prach_start[1][2]` for one cycle, exactly 1 cycle after `time_cnt`==1000.
  - Expect `prach_freq_offset`=-5, `prach_num_symbol`=12.
  - Expect `fifo_count` back to 0.
- Burst: 8 antennas of CC0, all at time=61440, with `time_cnt` held at 61440.
  - Expect 8 pulses at 2-cycle spacing, in ant order 0..7.
- Overflow: DEPTH+3 pushes with no match.
  - Expect `fifo_count`=DEPTH, `overflow_cnt`=3, and the first DEPTH entries intact, in order.
- Stale: push time=614500 (unreachable) and run 2 frames.
  - Expect the entry dropped on the 2nd frame tick, `drop_cnt`=1, no pulse.
  - Expect the following entry then issued normally.
- Edge cases:
  - Two `c_valid` bits high in one cycle: `multi_hit_err`=1, and the lower index is queued.
  - Push and pop in the same cycle: count unchanged.
  - `rst_n` low while in WAIT: FIFO empty, and no pulse afterwards.

Source files
------------

// File: rtl/prach_c_sched_if.sv
// prach_c_sched_if: decoded PRACH requests and frame time in, scheduled start pulses and status out.
interface prach_c_sched_if #(parameter int DEPTH = 8);
  logic [2:0][7:0]       c_valid;
  logic signed [16:0]    c_frequency_offset;
  logic [19:0]           c_time_offset;
  logic [3:0]            c_num_symbol;
  logic [119:0]          c_header;
  logic                  time_valid;
  logic [19:0]           time_cnt;
  logic [2:0][7:0]       prach_start;
  logic signed [16:0]    prach_freq_offset;
  logic [3:0]            prach_num_symbol;
  logic [119:0]          prach_header;
  logic [19:0]           prach_time;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]           overflow_cnt;
  logic [15:0]           drop_cnt;
  logic                  multi_hit_err;
  modport master (
    output c_valid, c_frequency_offset, c_time_offset, c_num_symbol, c_header, time_valid, time_cnt,
    input  prach_start, prach_freq_offset, prach_num_symbol, prach_header, prach_time,
    input  fifo_count, overflow_cnt, drop_cnt, multi_hit_err
  );
  modport slave (
    input  c_valid, c_frequency_offset, c_time_offset, c_num_symbol, c_header, time_valid, time_cnt,
    output prach_start, prach_freq_offset, prach_num_symbol, prach_header, prach_time,
    output fifo_count, overflow_cnt, drop_cnt, multi_hit_err
  );
endinterface

// File: rtl/prach_c_sched.sv
// prach_c_sched: queues decoded PRACH requests and releases each as a one-cycle start pulse at its frame time.
module prach_c_sched #(
  parameter int DEPTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  prach_c_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [1:0]   cc;
    logic [2:0]   ant;
    logic [16:0]  freq;
    logic [19:0]  t;
    logic [3:0]   nsym;
    logic [119:0] hdr;
  } entry_t;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
  state_t        state;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [23:0]   flat;
  logic [4:0]    sel;
  logic          frame_ticks, full, push, match, tick, drop, pop;
  assign flat = bus.c_valid;
  always_comb begin
    sel = '0;
    for (int i = 23; i >= 0; i--) if (flat[i]) sel = 5'(i);
  end
  assign head      = mem[rd_ptr];
  assign full      = count == (AW+1)'(DEPTH);
  assign push      = |flat && !full;
  assign match     = state == WAIT && head.t == bus.time_cnt;
  assign tick      = bus.time_valid && bus.time_cnt == '0;
  assign drop      = state == WAIT && !match && tick && frame_ticks;
  assign pop       = match || drop;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign bus.fifo_count = count;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel, bus.c_frequency_offset, bus.c_time_offset, bus.c_num_symbol, bus.c_header};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      wr_ptr                <= '0;
      rd_ptr                <= '0;
      count                 <= '0;
      frame_ticks           <= 1'b0;
      bus.prach_start       <= '0;
      bus.prach_freq_offset <= '0;
      bus.prach_num_symbol  <= '0;
      bus.prach_header      <= '0;
      bus.prach_time        <= '0;
      bus.overflow_cnt      <= '0;
      bus.drop_cnt          <= '0;
      bus.multi_hit_err     <= 1'b0;
    end else begin
      wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count       <= count_nxt;
      state       <= match ? ISSUE : (state == WAIT && !drop) ? WAIT : (count_nxt != '0) ? WAIT : IDLE;
      // first frame tick arms the stale check, the second one with no match drops the head
      frame_ticks <= state == WAIT && !pop && (frame_ticks || tick);
      bus.prach_start <= match ? 24'd1 << {head.cc, head.ant} : '0;
      if (match) begin
        bus.prach_freq_offset <= head.freq;
        bus.prach_num_symbol  <= head.nsym;
        bus.prach_header      <= head.hdr;
        bus.prach_time        <= head.t;
      end
      if (|flat && full && bus.overflow_cnt != 16'hFFFF) bus.overflow_cnt <= bus.overflow_cnt + 1'b1;
      if (drop && bus.drop_cnt != 16'hFFFF) bus.drop_cnt <= bus.drop_cnt + 1'b1;
      if ((flat & (flat - 1'b1)) != '0) bus.multi_hit_err <= 1'b1;
    end
  end
endmodule
